// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the FIFO read-side drain stage.
//   SKID_DEPTH  - number of skid entries behind the FIFO read port
//   OCC_W       - width of the skid occupancy count
//   occ_state_t - skid occupancy FSM states (encoding equals occupancy)
package fifo_pkg;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned OCC_W      = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry skid buffer with its occupancy FSM.
// Ports:
//   i_clk, i_rst_n  - clock, async active-low reset
//   i_cap           - a FIFO word is present on i_cap_data this cycle
//   i_cap_data      - captured word
//   i_beat          - head word is consumed at this edge
//   o_valid         - head entry holds a word
//   o_data          - head entry (entry 0)
//   o_occ           - current occupancy 0..2
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int unsigned SIZE_DATA = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cap,
  input  logic [SIZE_DATA-1:0] i_cap_data,
  input  logic                 i_beat,
  output logic                 o_valid,
  output logic [SIZE_DATA-1:0] o_data,
  output logic [OCC_W-1:0]     o_occ
);

  occ_state_t           r_state;
  logic                 r_valid;
  logic [SIZE_DATA-1:0] r_e0;
  logic [SIZE_DATA-1:0] r_e1;

  // Occupancy FSM and entry movement; entry 0 is always the oldest word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_EMPTY;
      r_valid <= 1'b0;
      r_e0    <= '0;
      r_e1    <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (i_cap) begin
            r_e0    <= i_cap_data;
            r_state <= S_ONE;
            r_valid <= 1'b1;
          end
        end
        S_ONE: begin
          if (i_cap && i_beat) begin
            // Head leaves while the new word takes its place.
            r_e0 <= i_cap_data;
          end else if (i_cap) begin
            r_e1    <= i_cap_data;
            r_state <= S_TWO;
          end else if (i_beat) begin
            r_state <= S_EMPTY;
            r_valid <= 1'b0;
          end
        end
        S_TWO: begin
          // Pop credit prevents a capture here unless a beat frees a slot.
          if (i_beat) begin
            r_e0 <= r_e1;
            if (i_cap) begin
              r_e1 <= i_cap_data;
            end else begin
              r_state <= S_ONE;
            end
          end
        end
        default: begin
          r_state <= S_EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_e0;
  assign o_occ   = OCC_W'(r_state);

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: converts an async-FIFO read port (empty, rd_en, 1-cycle
// read latency) into a valid/ready stream through a 2-entry skid buffer.
// Optional frame marking is enabled by defining FIFO_RD_STREAM_LAST_EN;
// when undefined, o_last is tied low and SIZE_FRAME has no effect.
// Ports:
//   i_clk, i_rst_n  - read-domain clock, async active-low reset
//   i_fifo_empty    - FIFO empty flag
//   o_fifo_rd_en    - FIFO pop request (combinational)
//   i_fifo_data     - FIFO read data, valid the cycle after a pop
//   o_valid/i_ready - stream handshake
//   o_data          - stream word
//   o_last          - final word of a SIZE_FRAME-word frame
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned SIZE_DATA  = 8,
  parameter int unsigned SIZE_FRAME = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_rd_en,
  input  logic [SIZE_DATA-1:0] i_fifo_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_data,
  output logic                 o_last
);

  if (SIZE_FRAME < 2) begin : g_bad_frame
    $error("fifo_rd_stream: SIZE_FRAME must be >= 2");
  end

  logic                 w_beat;
  logic                 w_valid;
  logic [SIZE_DATA-1:0] w_data;
  logic [OCC_W-1:0]     w_occ;
  logic [2:0]           w_credit;
  logic                 r_inflight;

  assign w_beat = w_valid && i_ready;

  // Slots committed after this edge: buffered + in flight - leaving.
  assign w_credit     = 3'(w_occ) + 3'(r_inflight) - 3'(w_beat);
  assign o_fifo_rd_en = i_rst_n && !i_fifo_empty && (w_credit < 3'(SKID_DEPTH));

  // A pop this cycle means read data is on i_fifo_data next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= o_fifo_rd_en;
    end
  end

  fifo_rd_skid #(
    .SIZE_DATA (SIZE_DATA)
  ) u_skid (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_cap      (r_inflight),
    .i_cap_data (i_fifo_data),
    .i_beat     (w_beat),
    .o_valid    (w_valid),
    .o_data     (w_data),
    .o_occ      (w_occ)
  );

  assign o_valid = w_valid;
  assign o_data  = w_data;

`ifdef FIFO_RD_STREAM_LAST_EN
  localparam int unsigned CNT_W = $clog2(SIZE_FRAME);

  logic [CNT_W-1:0] r_cnt;
  logic             r_last;

  // Beat counter; r_last mirrors (r_cnt == SIZE_FRAME-1) as a flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_last <= 1'b0;
    end else if (w_beat) begin
      if (r_last) begin
        r_cnt  <= '0;
        r_last <= 1'b0;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_last <= ((r_cnt + CNT_W'(1)) == CNT_W'(SIZE_FRAME - 1));
      end
    end
  end

  assign o_last = r_last;
`else
  assign o_last = 1'b0;
`endif

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain stage placed directly downstream of the asynchronous FIFO, in the read clock domain. It converts the FIFO read port (empty flag, read enable, one-cycle read latency) into a valid/ready stream with a 2-entry skid buffer, sustaining one word per cycle. It optionally marks frame boundaries with a last flag every `SIZE_FRAME` accepted words.

## Interface
- `SIZE_DATA`, 8: data word width.
- `SIZE_FRAME`, 16: words per frame for `o_last`; legal range is ≥2. Counter width is `$clog2(SIZE_FRAME)`.
- `i_clk`, input, 1: read-domain clock. This is the same clock as the FIFO read clock.
- `i_rst_n`, input, 1: reset, asynchronous and active-low.
- `i_fifo_empty`, input, 1: FIFO empty flag.
- `o_fifo_rd_en`, output, 1: FIFO pop request.
- `i_fifo_data`, input, `SIZE_DATA`: FIFO read data, valid one cycle after `o_fifo_rd_en`.
- `o_valid`, output, 1: stream word available.
- `i_ready`, input, 1: consumer accepts.
- `o_data`, output, `SIZE_DATA`: stream word.
- `o_last`, output, 1: final word of a frame.

## Operation
- Beat: `o_valid && i_ready` at a rising edge.
- Skid occupancy `occ` is 0..2. `inflight` is set in the cycle after `o_fifo_rd_en`.
- FSM states:
  - `S_EMPTY`: `occ` = 0.
  - `S_ONE`: `occ` = 1.
  - `S_TWO`: `occ` = 2.
- Transitions are driven by capture (`inflight`) and beat:
  - Capture only: `occ` + 1.
  - Beat only: `occ` − 1.
  - Capture and beat together: `occ` unchanged.
- Pop rule: `o_fifo_rd_en = i_rst_n && !i_fifo_empty && (occ + inflight − beat) < 2`.
  - Combinational from `i_fifo_empty`, `i_ready`, and state.
  - The skid buffer can never overflow.
- Skid buffer order:
  - Entry 0 drives `o_data`.
  - A captured word goes to entry 0 if it is free (or being vacated by a beat with entry 1 empty). Otherwise it goes to entry 1.
  - On a beat, entry 1 shifts into entry 0.
  - Strict FIFO order is preserved.
- `o_valid = (occ != 0)`.
- `o_data` and `o_last` hold stable while `o_valid && !i_ready`.
- Frame counter:
  - Increments on each beat.
  - `o_last` = 1 when the counter equals `SIZE_FRAME−1`.
  - The counter wraps to 0 on that beat.
- `i_fifo_empty` rising while a word is inflight: the inflight word is still captured. The empty flag only gates new pops.
- Simultaneous capture, beat and pop in `S_ONE`: the state stays `S_ONE` and throughput is 1/cycle.

## Timing
- Reset values:
  - `o_valid` = 0, `o_data` = 0, `o_last` = 0.
  - `o_fifo_rd_en` = 0 (gated by `i_rst_n`).
  - `occ` = 0, `inflight` = 0, frame counter = 0.
- Reset mid-operation clears the skid entries and `inflight`. The inflight word is discarded and the FIFO contents are untouched.
- Latency:
  - `i_fifo_empty` falls in cycle N → `o_fifo_rd_en` = 1 in N → data captured at the end of N+1 → `o_valid` = 1 in N+2.
- Throughput: with `i_ready` held high and the FIFO non-empty, there is one beat per cycle with no bubbles after fill.
- Backpressure: `i_ready` = 0 → at most 2 words buffered. `o_fifo_rd_en` deasserts in the same cycle the credit is exhausted.
- All state is updated on the rising edge of `i_clk`. There are no multicycle paths.

## Configuration
- Macro: `FIFO_RD_STREAM_LAST_EN`.
- Defined: frame counter and `o_last` generation as described.
- Undefined: no counter is instantiated and `o_last` is tied to 0. `SIZE_FRAME` is ignored. All other behaviour is identical.

## Structure
- Shared package `fifo_pkg` holds:
  - `localparam SKID_DEPTH = 2`.
  - The occupancy state typedef (`S_EMPTY`, `S_ONE`, `S_TWO`).
- Sub-module `fifo_rd_skid` contains:
  - The 2-entry skid register pair and its occupancy FSM.
  - Ports: capture strobe/data, beat, `o_valid`, `o_data`, `occ`.
- The top level holds the pop-credit logic, the `inflight` flop and the frame counter.

## Test plan
- **Reset then fill:** hold `i_fifo_empty` = 0, `i_ready` = 1, and feed 0x01, 0x02, 0x03 … → first `o_valid` 2 cycles after reset release, then one beat per cycle in order.
- **Backpressure:** `i_ready` = 0 for 10 cycles with the FIFO non-empty → exactly 2 pops, `o_fifo_rd_en` = 0 afterwards, `o_data` stable. On release, words continue in order with no loss or duplicate.
- **Empty boundary:** FIFO goes empty right after a pop → the inflight word is delivered, then `o_valid` = 0 and `o_fifo_rd_en` = 0 until empty falls.
- **Frame marking (macro defined, `SIZE_FRAME` = 4):** 9 beats → `o_last` = 1 on beats 4 and 8 only. With ready toggled 1/0, `o_last` holds on stalled beats.
- **Reset mid-operation:** assert `i_rst_n` = 0 with `occ` = 2 and `inflight` = 1 → all outputs 0 immediately. After release, the next word comes from the FIFO, and the frame counter restarts at 0.
- **Macro undefined:** repeat the frame test → `o_last` stays 0 and data is identical.
